pipe1_bus_arbiter: RTL and testbench
====================================

// Module: pipe1_bus_arbiter
// PURPOSE
//  Shares the CPU memory bus between the instruction pipeline and NUM_REQ external bus masters (DMA, video).
//  Raises BusRequest to Pipeline Stage 1, waits for its FetchSurpress acknowledge, then grants the bus.
//  Grants go to one requester at a time, in round-robin order, for a bounded burst.
//  Always returns the bus to the pipeline between grants, so instruction fetch keeps progressing.
// PARAMETERS
//  NUM_REQ    2   number of external bus masters (2..8)
//  MAX_BURST  16  max consecutive grant cycles per tenure (1..255)
//  CNT_W      $clog2(MAX_BURST+1)  burst counter width (derived, do not override)
//  ID_W       (NUM_REQ>2)?$clog2(NUM_REQ):1  grant index width (derived)
// PORTS
//  ClockIn        in   1        system clock, rising edge
//  Reset_n        in   1        asynchronous, active-low reset
//  Req            in   NUM_REQ  per-master bus request, level, held until done
//  FetchSurpress  in   1        Stage 1 acknowledge: pipeline has released the bus
//  BusRequest     out  1        to Stage 1: request pipeline suppress fetch
//  Grant          out  NUM_REQ  one-hot bus grant, registered
//  GrantValid     out  1        OR of Grant
//  GrantId        out  ID_W     index of granted master (holds last value when idle)
//  BurstCount     out  CNT_W    cycles of current tenure, 1..MAX_BURST; 0 when not granting
//  ProtocolErr    out  1        sticky: FetchSurpress dropped while granting
// BEHAVIOUR
//  Reset (async, Reset_n=0): all outputs 0, state IDLE, round-robin pointer=0, ProtocolErr=0.
//    Takes effect immediately, mid-tenure included; Grant drops without waiting for a clock.
//  All outputs are registered. Four states:
//  IDLE:  BusRequest=0, Grant=0.
//    If |Req at edge k -> WAIT_ACK; BusRequest=1 after edge k.
//  WAIT_ACK:  BusRequest=1, Grant=0.
//    If Req==0 at an edge -> RELEASE (requesters withdrew; no grant).
//    Else if FetchSurpress=1 at edge m -> pick winner = first set Req bit at/after pointer, wrapping.
//      Then -> GRANT; after edge m: Grant[w]=1, GrantId=w, BurstCount=1.
//    Winner is chosen at the ack edge, not at request time; a late higher-pointer request can win.
//    No timeout: waits indefinitely for FetchSurpress.
//  GRANT:  BusRequest=1, Grant[w]=1. Each edge:
//    FetchSurpress=0 -> ProtocolErr<=1 (sticky until reset); -> RELEASE (abort). Highest priority.
//    else Req[w]=0 or BurstCount==MAX_BURST -> RELEASE.
//    else BurstCount<=BurstCount+1 (never exceeds MAX_BURST, no wrap).
//    Requests from other masters never preempt a tenure.
//  RELEASE:  BusRequest=0, Grant=0, BurstCount=0.
//    On entry from GRANT: pointer <= (w+1) mod NUM_REQ. On entry from WAIT_ACK: pointer unchanged.
//    Always exactly one cycle, then -> IDLE.
//  Grant lifetime:
//    Grant is high for at most MAX_BURST cycles.
//    After Req[w] falls, Grant falls one edge later.
//  Pipeline gap: with requests continuously pending, BusRequest drops for >=2 cycles (RELEASE, IDLE) between tenures.
//  Latency: Req rise to BusRequest = 1 edge. FetchSurpress rise to Grant = 1 edge.
//  Req bits for non-granted masters may change at any time; they are only sampled in IDLE/WAIT_ACK.
//  Exactly one Grant bit is ever high; GrantValid==|Grant.
// TESTING
//  1 Reset_n=0 asserted mid-GRANT (async, between edges)
//    -> Grant, BusRequest, BurstCount go to 0 without a clock edge.
//    -> After release, Req=01, ack gives Grant=01 (pointer back to 0).
//  2 Req=01, FetchSurpress rises 3 cycles after BusRequest
//    -> Grant=01 one edge after ack.
//    -> Req dropped after 5 grant cycles: Grant high 6 cycles, BusRequest low for 2, BurstCount peak 6.
//  3 Req=11 held continuously, FetchSurpress tied to BusRequest delayed 1 cycle
//    -> grants alternate 01,10,01.
//    -> Each grant lasts 16 cycles; BurstCount reaches 16, never 17.
//  4 Req=10 then withdrawn to 00 in WAIT_ACK before ack
//    -> no Grant; BusRequest drops; pointer unchanged.
//  5 FetchSurpress forced low in cycle 4 of a tenure
//    -> ProtocolErr=1 (stays set); Grant drops after that edge; next tenure still proceeds normally.
//  6 NUM_REQ=3, MAX_BURST=1, Req=111
//    -> single-cycle grants in order 001,010,100,001; GrantId 0,1,2,0.

Source files
------------

// File: rtl/pipe1_bus_arbiter.sv
// pipe1_bus_arbiter
//   Shares the CPU memory bus between the instruction pipeline and NUM_REQ
//   external bus masters (DMA, video). A pending request first raises
//   BusRequest to pipeline stage 1. Once stage 1 acknowledges with
//   FetchSurpress, one master is granted the bus in round-robin order for a
//   burst of at most MAX_BURST cycles. The bus always goes back to the
//   pipeline between tenures: BusRequest is low for at least two cycles,
//   the RELEASE and IDLE states.
//
// Ports
//   ClockIn        in   1        system clock, rising edge
//   Reset_n        in   1        asynchronous active-low reset
//   Req            in   NUM_REQ  per-master level request, held until done
//   FetchSurpress  in   1        stage 1 acknowledge: pipeline released the bus
//   BusRequest     out  1        ask stage 1 to suppress instruction fetch
//   Grant          out  NUM_REQ  one-hot registered bus grant
//   GrantValid     out  1        OR of Grant
//   GrantId        out  ID_W     index of granted master, holds when idle
//   BurstCount     out  CNT_W    cycle number within the tenure, 0 when idle
//   ProtocolErr    out  1        sticky: FetchSurpress dropped mid-tenure
module pipe1_bus_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = $clog2(MAX_BURST + 1),
    parameter int ID_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic               ClockIn,
    input  logic               Reset_n,
    input  logic [NUM_REQ-1:0] Req,
    input  logic               FetchSurpress,
    output logic               BusRequest,
    output logic [NUM_REQ-1:0] Grant,
    output logic               GrantValid,
    output logic [ID_W-1:0]    GrantId,
    output logic [CNT_W-1:0]   BurstCount,
    output logic               ProtocolErr
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        GRANT    = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [ID_W-1:0]    winner;
    logic               bus_req_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [ID_W-1:0]    id_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               err_nxt;

    // First requesting master at or after the pointer, wrapping around.
    function automatic logic [ID_W-1:0] pick_winner(input logic [NUM_REQ-1:0] req,
                                                    input logic [ID_W-1:0]    start);
        logic [ID_W-1:0] w;
        logic            found;
        int              idx;
        w     = start;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(start) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                w     = ID_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = (int'(id) == i);
        end
        return v;
    endfunction

    // The winner is evaluated continuously but only used at the ack edge,
    // so a request arriving during WAIT_ACK can still take the bus.
    assign winner = pick_winner(Req, ptr);

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        bus_req_nxt = 1'b0;
        grant_nxt   = '0;
        id_nxt      = GrantId;
        cnt_nxt     = '0;
        err_nxt     = ProtocolErr;
        case (state)
            IDLE: begin
                if (|Req) begin
                    state_nxt   = WAIT_ACK;
                    bus_req_nxt = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (Req == '0) begin
                    // Everyone withdrew before the ack; the pointer is kept.
                    state_nxt = RELEASE;
                end else begin
                    bus_req_nxt = 1'b1;
                    if (FetchSurpress) begin
                        state_nxt = GRANT;
                        grant_nxt = to_onehot(winner);
                        id_nxt    = winner;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            GRANT: begin
                // Losing the ack is checked first and aborts the tenure;
                // other masters' requests never preempt it.
                if (!FetchSurpress || ((Req & Grant) == '0) || (BurstCount == MAX_CNT)) begin
                    state_nxt = RELEASE;
                    ptr_nxt   = (GrantId == LAST_ID) ? '0 : GrantId + ID_W'(1);
                    err_nxt   = ProtocolErr | ~FetchSurpress;
                end else begin
                    bus_req_nxt = 1'b1;
                    grant_nxt   = Grant;
                    cnt_nxt     = BurstCount + CNT_W'(1);
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge ClockIn or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            BusRequest  <= 1'b0;
            Grant       <= '0;
            GrantValid  <= 1'b0;
            GrantId     <= '0;
            BurstCount  <= '0;
            ProtocolErr <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            BusRequest  <= bus_req_nxt;
            Grant       <= grant_nxt;
            GrantValid  <= |grant_nxt;
            GrantId     <= id_nxt;
            BurstCount  <= cnt_nxt;
            ProtocolErr <= err_nxt;
        end
    end

endmodule

// File: tb/tb_pipe1_bus_arbiter.sv
module tb_pipe1_bus_arbiter;

    localparam int NR = 2;
    localparam int MB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic       fs;
    logic       br;
    logic [1:0] grant;
    logic       gv;
    logic [0:0] gid;
    logic [4:0] cnt;
    logic       err;

    logic [2:0] req_b;
    logic       fs_b;
    logic       br_b;
    logic [2:0] grant_b;
    logic       gv_b;
    logic [1:0] gid_b;
    logic [0:0] cnt_b;
    logic       err_b;

    always #5 clk = ~clk;

    pipe1_bus_arbiter #(.NUM_REQ(2), .MAX_BURST(16)) dut_a (
        .ClockIn(clk), .Reset_n(rst_n), .Req(req), .FetchSurpress(fs),
        .BusRequest(br), .Grant(grant), .GrantValid(gv), .GrantId(gid),
        .BurstCount(cnt), .ProtocolErr(err)
    );

    pipe1_bus_arbiter #(.NUM_REQ(3), .MAX_BURST(1)) dut_b (
        .ClockIn(clk), .Reset_n(rst_n), .Req(req_b), .FetchSurpress(fs_b),
        .BusRequest(br_b), .Grant(grant_b), .GrantValid(gv_b), .GrantId(gid_b),
        .BurstCount(cnt_b), .ProtocolErr(err_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for dut_a: who owns the bus, how long they have had it,
    // whose turn is next, and how many cycles the pipeline must keep the bus.
    int m_owner;
    int m_cnt;
    int m_ptr;
    int m_id;
    int m_cool;
    bit m_br;
    bit m_err;

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_id    = 0;
        m_cool  = 0;
        m_br    = 1'b0;
        m_err   = 1'b0;
    endtask

    function automatic int pick(input logic [1:0] r, input int p);
        for (int k = 0; k < NR; k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_edge();
        if (m_owner >= 0) begin
            if (!fs || !req[m_owner] || m_cnt == MB) begin
                if (!fs) m_err = 1'b1;
                m_ptr   = (m_owner + 1) % NR;
                m_owner = -1;
                m_cnt   = 0;
                m_br    = 1'b0;
                m_cool  = 1;
            end else begin
                m_cnt++;
            end
        end else if (m_br) begin
            if (req == 2'b00) begin
                m_br   = 1'b0;
                m_cool = 1;
            end else if (fs) begin
                m_owner = pick(req, m_ptr);
                m_id    = m_owner;
                m_cnt   = 1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (req != 2'b00) begin
            m_br = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        check("model busreq", br, m_br);
        check("model grant", grant, (m_owner >= 0) ? (1 << m_owner) : 0);
        check("model gvalid", gv, m_owner >= 0);
        check("model gid", gid, m_id);
        check("model burst", cnt, m_cnt);
        check("model perr", err, m_err);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        fs    = 1'b0;
        req_b = 3'b000;
        fs_b  = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] req;
        logic       fs;
        logic       br;
        logic [1:0] grant;
        logic [4:0] cnt;
        logic [0:0] id;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] r, input logic f, input logic b,
                       input logic [1:0] g, input logic [4:0] c, input logic [0:0] i);
        vec_t v;
        v.req = r; v.fs = f; v.br = b; v.grant = g; v.cnt = c; v.id = i;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic br_d;
        int   owners[$];
        int   lens[$];
        int   maxcnt, len, lowrun, mingap;
        bit   prev_gv, seen;
        int   exp_g[4];
        int   exp_id[4];
        int   seq_g[$];
        int   seq_id[$];

        rst_n = 1'b0; req = 2'b00; fs = 1'b0; req_b = 3'b000; fs_b = 1'b0;
        model_reset();
        #12;
        check("rst busreq", br, 0);
        check("rst grant", grant, 0);
        check("rst gvalid", gv, 0);
        check("rst gid", gid, 0);
        check("rst burst", cnt, 0);
        check("rst perr", err, 0);
        check("rst b busreq", br_b, 0);
        check("rst b grant", grant_b, 0);
        check("rst b burst", cnt_b, 0);
        step();
        rst_n = 1'b1;

        // Ack 3 cycles after BusRequest, 6-cycle tenure, then a withdrawn
        // request and pointer checks.
        add(2'b01, 0, 1, 2'b00, 0, 0);
        add(2'b01, 0, 1, 2'b00, 0, 0);
        add(2'b01, 0, 1, 2'b00, 0, 0);
        add(2'b01, 1, 1, 2'b01, 1, 0);
        add(2'b01, 1, 1, 2'b01, 2, 0);
        add(2'b01, 1, 1, 2'b01, 3, 0);
        add(2'b01, 1, 1, 2'b01, 4, 0);
        add(2'b01, 1, 1, 2'b01, 5, 0);
        add(2'b01, 1, 1, 2'b01, 6, 0);
        add(2'b00, 1, 0, 2'b00, 0, 0);
        add(2'b00, 0, 0, 2'b00, 0, 0);
        add(2'b10, 0, 1, 2'b00, 0, 0);
        add(2'b00, 0, 0, 2'b00, 0, 0);
        add(2'b00, 0, 0, 2'b00, 0, 0);
        add(2'b11, 0, 1, 2'b00, 0, 0);
        add(2'b11, 1, 1, 2'b10, 1, 1);
        add(2'b00, 1, 0, 2'b00, 0, 1);
        add(2'b00, 0, 0, 2'b00, 0, 1);
        add(2'b11, 0, 1, 2'b00, 0, 1);
        add(2'b11, 1, 1, 2'b01, 1, 0);
        add(2'b00, 1, 0, 2'b00, 0, 0);
        add(2'b00, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            req = tbl[i].req;
            fs  = tbl[i].fs;
            step();
            check("tbl busreq", br, tbl[i].br);
            check("tbl grant", grant, tbl[i].grant);
            check("tbl burst", cnt, tbl[i].cnt);
            check("tbl gid", gid, tbl[i].id);
        end

        // Async reset in the middle of a tenure, pointer returns to 0.
        req = 2'b10; fs = 1'b0;
        step();
        fs = 1'b1;
        step();
        step();
        check("t1 granted before reset", grant, 2'b10);
        #3;
        rst_n = 1'b0;
        #1;
        check("t1 async grant", grant, 0);
        check("t1 async busreq", br, 0);
        check("t1 async burst", cnt, 0);
        check("t1 async gvalid", gv, 0);
        model_reset();
        req = 2'b00; fs = 1'b0;
        step();
        rst_n = 1'b1;
        req = 2'b11;
        step();
        fs = 1'b1;
        step();
        check("t1 grant after reset", grant, 2'b01);
        req = 2'b00; fs = 1'b0;
        step();
        step();

        // Continuous requests, ack follows BusRequest one cycle late.
        apply_reset();
        req = 2'b11; br_d = 1'b0;
        maxcnt = 0; len = 0; lowrun = 0; mingap = 1000; prev_gv = 0; seen = 0;
        for (int c = 0; c < 64; c++) begin
            fs   = br_d;
            br_d = br;
            step();
            if (gv && !prev_gv) owners.push_back(int'(grant));
            if (gv) len++;
            if (!gv && prev_gv) begin
                lens.push_back(len);
                len = 0;
            end
            if (int'(cnt) > maxcnt) maxcnt = int'(cnt);
            if (!br) lowrun++;
            else begin
                if (seen && lowrun > 0 && lowrun < mingap) mingap = lowrun;
                lowrun = 0;
            end
            if (gv) seen = 1;
            prev_gv = gv;
        end
        check("t3 owner0", (owners.size() > 0) ? owners[0] : -1, 1);
        check("t3 owner1", (owners.size() > 1) ? owners[1] : -1, 2);
        check("t3 owner2", (owners.size() > 2) ? owners[2] : -1, 1);
        for (int k = 0; k < 3; k++) begin
            check("t3 tenure length", (lens.size() > k) ? lens[k] : -1, 16);
        end
        check("t3 burst peak", maxcnt, 16);
        check("t3 gap at least 2", mingap >= 2, 1);

        // Ack dropped in cycle 4 of a tenure.
        apply_reset();
        req = 2'b01; br_d = 1'b0;
        for (int c = 0; c < 20; c++) begin
            fs   = br_d;
            br_d = br;
            step();
            if (cnt == 5'd4) break;
        end
        check("t5 reached burst 4", cnt, 4);
        fs = 1'b0;
        step();
        check("t5 perr set", err, 1);
        check("t5 grant dropped", gv, 0);
        for (int c = 0; c < 20; c++) begin
            fs   = br_d;
            br_d = br;
            step();
            if (gv) break;
        end
        check("t5 next tenure grant", grant, 2'b01);
        check("t5 perr sticky", err, 1);
        for (int c = 0; c < 5; c++) begin
            fs   = br_d;
            br_d = br;
            step();
        end
        check("t5 perr still set", err, 1);

        // Three masters, single-cycle bursts.
        apply_reset();
        req_b = 3'b111; fs_b = 1'b1;
        exp_g  = '{1, 2, 4, 1};
        exp_id = '{0, 1, 2, 0};
        prev_gv = 0;
        for (int c = 0; c < 24; c++) begin
            step();
            if (gv_b) begin
                seq_g.push_back(int'(grant_b));
                seq_id.push_back(int'(gid_b));
                check("t6 burst is 1", cnt_b, 1);
                check("t6 single cycle", prev_gv, 0);
            end
            prev_gv = gv_b;
        end
        for (int k = 0; k < 4; k++) begin
            check("t6 grant order", (seq_g.size() > k) ? seq_g[k] : -1, exp_g[k]);
            check("t6 grant id", (seq_id.size() > k) ? seq_id[k] : -1, exp_id[k]);
        end
        req_b = 3'b000; fs_b = 1'b0;

        // Randomized traffic against the model.
        apply_reset();
        br_d = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                apply_reset();
                br_d = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) fs = 1'($urandom_range(0, 1));
            else fs = br_d;
            br_d = br;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
